neuron_mac: RTL and testbench

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/nn_pkg.sv | 14 +
 rtl/act_clamp.sv | 39 +++
 rtl/neuron_mac.sv | 130 +++++++++++++
 tb/tb_neuron_mac.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared state encoding and default widths for the neuron MAC slice
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } mac_state_t;

  localparam int ACT_N     = 10;
  localparam int DATA_W    = 16;
  localparam int ACT_SHIFT = 8;

endpackage

// File: rtl/act_clamp.sv
// rtl/act_clamp.sv - combinational map from accumulator sum to activation code and slope
// Code is offset to mid-scale and clamped to [0, 2^N-1]; slope is |sum| clamped to 32 bits.
module act_clamp #(
  parameter int AW    = 36,
  parameter int N     = 10,
  parameter int SHIFT = 8
) (
  input  logic signed [AW-1:0] sum_i,
  output logic        [N-1:0]  out_o,
  output logic                 clamped_o,
  output logic        [31:0]   slope_o
);

  localparam logic signed [AW:0] OFFSET = (AW+1)'(2 ** (N - 1));
  localparam logic signed [AW:0] MAXV   = (AW+1)'(2 ** N - 1);

  logic signed [AW-1:0] shifted;
  logic signed [AW:0]   s;
  logic        [AW:0]   mag;
  logic                 over;

  always_comb begin
    shifted   = sum_i >>> SHIFT;
    s         = {shifted[AW-1], shifted} + OFFSET;
    over      = !s[AW] && (s > MAXV);
    clamped_o = s[AW] || over;
    if (s[AW]) begin
      out_o = '0;
    end else if (over) begin
      out_o = '1;
    end else begin
      out_o = s[N-1:0];
    end
    // One extra bit so the most negative sum negates without wrapping.
    mag     = sum_i[AW-1] ? ((AW+1)'(0) - {sum_i[AW-1], sum_i}) : {1'b0, sum_i};
    slope_o = (|mag[AW:32]) ? 32'hFFFF_FFFF : mag[31:0];
  end

endmodule

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - streaming multiply-accumulate neuron with clamped activation output
// Optional saturation counter output enabled by NEURON_MAC_SAT_CNT_EN.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int N     = ACT_N,
  parameter int W     = DATA_W,
  parameter int SHIFT = ACT_SHIFT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] bias,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] w,
  input  logic                last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic        [N-1:0] out,
  output logic        [31:0]  slope
`ifdef NEURON_MAC_SAT_CNT_EN
  ,
  output logic        [15:0]  sat_count
`endif
);

  localparam int AW = 2 * W + 4;

  mac_state_t state_q, state_d;

  logic signed [AW-1:0]  acc_q;
  logic signed [AW-1:0]  sum;
  logic signed [2*W-1:0] prod;
  logic        [N-1:0]   out_q, clamp_out;
  logic        [31:0]    slope_q, clamp_slope;
  logic                  out_valid_q, exit_q, clamped;
  logic                  accept, out_hs;

  assign prod   = x * w;
  assign sum    = ((state_q == IDLE) ? {{(AW-W){bias[W-1]}}, bias} : acc_q)
                + {{(AW-2*W){prod[2*W-1]}}, prod};
  assign accept = in_valid && in_ready;
  assign out_hs = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = last ? HOLD : ACCUM;
      ACCUM:   if (accept && last) state_d = HOLD;
      HOLD:    if (out_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The cycle right after an output handshake is a dead cycle for input.
  always_comb begin
    in_ready = !rst && (state_q != HOLD) && !exit_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      out_q       <= '0;
      slope_q     <= '0;
      out_valid_q <= 1'b0;
      exit_q      <= 1'b0;
    end else begin
      exit_q <= out_hs;
      if (accept) begin
        acc_q <= sum;
      end
      if (accept && last) begin
        out_q       <= clamp_out;
        slope_q     <= clamp_slope;
        out_valid_q <= 1'b1;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  act_clamp #(
    .AW   (AW),
    .N    (N),
    .SHIFT(SHIFT)
  ) u_act_clamp (
    .sum_i    (sum),
    .out_o    (clamp_out),
    .clamped_o(clamped),
    .slope_o  (clamp_slope)
  );

  assign out       = out_q;
  assign slope     = slope_q;
  assign out_valid = out_valid_q;

`ifdef NEURON_MAC_SAT_CNT_EN
  logic        clamp_q;
  logic [15:0] sat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clamp_q <= 1'b0;
      sat_q   <= '0;
    end else begin
      if (accept && last) begin
        clamp_q <= clamped;
      end
      if (out_hs && clamp_q && (sat_q != 16'hFFFF)) begin
        sat_q <= sat_q + 16'd1;
      end
    end
  end

  assign sat_count = sat_q;
`else
  logic sat_unused;
  assign sat_unused = clamped;
`endif

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - directed self-checking bench for neuron_mac with a sum-level model
module tb_neuron_mac;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] bias = '0;
  logic signed [15:0] x = '0;
  logic signed [15:0] w = '0;
  logic               in_valid = 1'b0;
  logic               last = 1'b0;
  logic               out_ready = 1'b1;
  logic               in_ready, out_valid;
  logic        [9:0]  out;
  logic        [31:0] slope;
`ifdef NEURON_MAC_SAT_CNT_EN
  logic        [15:0] sat_count;
`endif

  neuron_mac dut (
    .clk      (clk),
    .rst      (rst),
    .bias     (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .w        (w),
    .last     (last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .slope    (slope)
`ifdef NEURON_MAC_SAT_CNT_EN
    ,
    .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  longint      exp_q[$];
  int          sat_m = 0;
  bit          started = 0;
  bit          chk_run = 0;
  int          low_run = 0;
  bit          lat_pend = 0;
  bit          hold_pend = 0;
  logic [9:0]  h_out;
  logic [31:0] h_slope;
  logic signed [15:0] vx[8];
  logic signed [15:0] vw[8];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint floor_act(input longint s);
    longint q;
    q = s / 256;
    if (s < 0 && (s % 256) != 0) q = q - 1;
    return q + 512;
  endfunction

  function automatic longint exp_out(input longint s);
    longint q;
    q = floor_act(s);
    if (q < 0) return 0;
    if (q > 1023) return 1023;
    return q;
  endfunction

  function automatic bit exp_clamped(input longint s);
    longint q;
    q = floor_act(s);
    return (q < 0) || (q > 1023);
  endfunction

  function automatic longint exp_slope(input longint s);
    longint m;
    m = (s < 0) ? -s : s;
    return (m > 64'd4294967295) ? 64'd4294967295 : m;
  endfunction

  always @(negedge clk) begin
    if (started) begin
`ifdef NEURON_MAC_SAT_CNT_EN
      chk("sat_count", longint'(sat_count), longint'(sat_m));
`endif
      if (lat_pend) chk("out_valid_latency", longint'(out_valid), 1);
      if (hold_pend) begin
        chk("hold_valid", longint'(out_valid), 1);
        chk("hold_out", longint'(out), longint'(h_out));
        chk("hold_slope", longint'(slope), longint'(h_slope));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual out=%0d slope=%0d required no result pending", out, slope);
        end else begin
          chk("model_out", longint'(out), exp_out(exp_q[0]));
          chk("model_slope", longint'(slope), exp_slope(exp_q[0]));
        end
      end
      if (chk_run) begin
        if (!in_ready) begin
          low_run++;
        end else begin
          if (low_run != 0) chk("in_ready_low_run", longint'(low_run), 2);
          low_run = 0;
        end
      end
      lat_pend  = in_valid && in_ready && last && !rst;
      hold_pend = out_valid && !out_ready && !rst;
      h_out     = out;
      h_slope   = slope;
      if (rst) begin
        exp_q.delete();
        sat_m = 0;
      end else if (out_valid && out_ready && exp_q.size() > 0) begin
        if (exp_clamped(exp_q[0]) && sat_m != 65535) sat_m++;
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic setv(input int i, input int a, input int b);
    vx[i] = 16'(a);
    vw[i] = 16'(b);
  endtask

  task automatic beat(input logic signed [15:0] xv, input logic signed [15:0] wv, input bit lst);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    x = xv;
    w = wv;
    last = lst;
    in_valid = 1'b1;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = in_ready && !rst;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_accept actual=not accepted within %0d cycles required=accepted", n);
    end
  endtask

  // Leaves in_valid high so a following vector can start with no gap.
  task automatic send_vec(input logic signed [15:0] b, input int n);
    longint s;
    s = b;
    for (int i = 0; i < n; i++) s = s + longint'(vx[i]) * longint'(vw[i]);
    exp_q.push_back(s);
    bias = b;
    for (int i = 0; i < n; i++) beat(vx[i], vw[i], i == n - 1);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_out actual=no out_valid in %0d cycles required=out_valid", n);
    end
  endtask

  task automatic lit_result(input string name, input longint eo, input longint es);
    @(negedge clk);
    chk({name, "_valid"}, longint'(out_valid), 1);
    chk({name, "_out"}, longint'(out), eo);
    chk({name, "_slope"}, longint'(slope), es);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) begin
      @(posedge clk);
      #1;
      started = 1;
      @(negedge clk);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_in_ready", longint'(in_ready), 0);
      chk("rst_out", longint'(out), 0);
      chk("rst_slope", longint'(slope), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    // Two-beat cancelling vector, out must appear one clock after last.
    setv(0, 256, 256);
    setv(1, 256, -256);
    send_vec(16'sd0, 2);
    idle_in();
    lit_result("s1", 512, 0);

    setv(0, 16384, 16384);
    send_vec(16'sd0, 1);
    idle_in();
    lit_result("s2", 1023, 268435456);
`ifdef NEURON_MAC_SAT_CNT_EN
    @(negedge clk);
    chk("s2_sat_count", longint'(sat_count), 1);
    @(posedge clk);
    #1;
`endif

    setv(0, 0, 0);
    send_vec(-16'sd32768, 1);
    idle_in();
    lit_result("s3", 384, 32768);

    setv(0, 0, 0);
    send_vec(-16'sd1, 1);
    idle_in();
    lit_result("floor_neg", 511, 1);

    for (int i = 0; i < 5; i++) setv(i, -32768, -32768);
    send_vec(16'sd0, 5);
    idle_in();
    lit_result("slope_clamp_pos", 1023, 64'd4294967295);

    for (int i = 0; i < 5; i++) setv(i, -32768, 32767);
    send_vec(16'sd0, 5);
    idle_in();
    lit_result("slope_clamp_neg", 0, 64'd4294967295);

    // Downstream stall: output held, input refused.
    out_ready = 1'b0;
    setv(0, 512, 2);
    setv(1, -3, 100);
    send_vec(16'sd0, 2);
    idle_in();
    wait_out();
    chk("stall_out", longint'(out), 514);
    chk("stall_slope", longint'(slope), 724);
    x = 16'sd1;
    w = 16'sd1;
    last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      @(negedge clk);
      chk("stall_in_ready", longint'(in_ready), 0);
      chk("stall_out_valid", longint'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    idle_in();
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-vector, colliding with the final beat.
    bias = 16'sd7;
    beat(16'sd100, 16'sd100, 1'b0);
    beat(16'sd100, 16'sd100, 1'b0);
    x = 16'sd100;
    w = 16'sd100;
    last = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", longint'(in_ready), 0);
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    @(posedge clk);
    #1;
    idle_in();
    @(negedge clk);
    chk("mid_rst_out_valid2", longint'(out_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_out_valid", longint'(out_valid), 0);
    chk("after_rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    setv(0, 1, 256);
    send_vec(16'sd0, 1);
    idle_in();
    lit_result("post_rst_vec", 513, 256);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back vectors with no idle between them.
    low_run = 0;
    chk_run = 1;
    setv(0, -300, 7);
    setv(1, 20, 50);
    send_vec(16'sd1000, 2);
    setv(0, 1000, 1000);
    send_vec(16'sd0, 1);
    setv(0, -2, 3);
    setv(1, 4, 4);
    setv(2, 1, 1);
    send_vec(16'sd5, 3);
    idle_in();
    repeat (4) @(posedge clk);
    #1;
    chk_run = 0;
    chk("results_drained", longint'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=time limit reached required=finish");
    $fatal(1);
  end

endmodule
